// File: rtl/sram_ctrl.sv
// External SRAM sequencer: 64-bit line reads (two words) and single-word writes,
// each SRAM word held for WAIT_CYCLES cycles, with a one-cycle ready pulse on completion.
module sram_ctrl #(
   parameter int unsigned WAIT_CYCLES = 5,
   parameter int unsigned ADDR_W      = 18,
   parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_rd,
   input  logic              req_wr,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic [63:0]       rdata,
   output logic              ready,
   output logic              busy,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_dq_o,
   output logic              sram_dq_oe,
   input  logic [31:0]       sram_dq_i,
   output logic              sram_we_n,
   output logic [31:0]       rd_count,
   output logic [31:0]       wr_count
);

   typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR, DONE} state_t;

   localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

   state_t            state;
   logic [3:0]        cnt;
   logic [ADDR_W-1:0] wa;

   assign wa = ADDR_W'((addr - BASE_ADDR) >> 2);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         ready      <= 1'b0;
         busy       <= 1'b0;
         rdata      <= '0;
         sram_addr  <= '0;
         sram_dq_o  <= '0;
         sram_dq_oe <= 1'b0;
         sram_we_n  <= 1'b1;
         rd_count   <= '0;
         wr_count   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               cnt <= '0;
               // Address and data are captured only on acceptance, so the SRAM bus stays quiet while idle.
               if (req_wr) begin
                  state      <= WR;
                  busy       <= 1'b1;
                  sram_addr  <= wa;
                  sram_dq_o  <= wdata;
                  sram_dq_oe <= 1'b1;
                  sram_we_n  <= 1'b0;
               end else if (req_rd) begin
                  state     <= RD_LO;
                  busy      <= 1'b1;
                  sram_addr <= {wa[ADDR_W-1:1], 1'b0};
               end
            end
            RD_LO: begin
               if (cnt == CNT_LAST) begin
                  rdata[31:0] <= sram_dq_i;
                  cnt         <= '0;
                  sram_addr   <= {sram_addr[ADDR_W-1:1], 1'b1};
                  state       <= RD_HI;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            RD_HI: begin
               if (cnt == CNT_LAST) begin
                  rdata[63:32] <= sram_dq_i;
                  cnt          <= '0;
                  ready        <= 1'b1;
                  rd_count     <= rd_count + 32'd1;
                  state        <= DONE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            WR: begin
               if (cnt == CNT_LAST) begin
                  cnt        <= '0;
                  sram_we_n  <= 1'b1;
                  sram_dq_oe <= 1'b0;
                  ready      <= 1'b1;
                  wr_count   <= wr_count + 32'd1;
                  state      <= DONE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            DONE: begin
               ready <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               ready <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: SRAM array model plus a scoreboard of expected
// completions popped on every ready pulse.
module tb_sram_ctrl;

   localparam int unsigned W      = 5;
   localparam int unsigned ADDR_W = 18;
   localparam logic [31:0] BASE   = 32'd1024;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_rd;
   logic              req_wr;
   logic [31:0]       addr;
   logic [31:0]       wdata;
   logic [63:0]       rdata;
   logic              ready;
   logic              busy;
   logic [ADDR_W-1:0] sram_addr;
   logic [31:0]       sram_dq_o;
   logic              sram_dq_oe;
   logic [31:0]       sram_dq_i;
   logic              sram_we_n;
   logic [31:0]       rd_count;
   logic [31:0]       wr_count;

   typedef struct {
      logic        is_rd;
      logic [63:0] data;
      int unsigned word;
   } exp_t;

   exp_t        sb[$];
   int unsigned checks   = 0;
   int unsigned failures = 0;

   logic [31:0] mem     [0:255];
   logic [31:0] ref_mem [0:255];
   logic        mem_init;

   sram_ctrl #(
      .WAIT_CYCLES(W),
      .ADDR_W     (ADDR_W),
      .BASE_ADDR  (BASE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_rd    (req_rd),
      .req_wr    (req_wr),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .ready     (ready),
      .busy      (busy),
      .sram_addr (sram_addr),
      .sram_dq_o (sram_dq_o),
      .sram_dq_oe(sram_dq_oe),
      .sram_dq_i (sram_dq_i),
      .sram_we_n (sram_we_n),
      .rd_count  (rd_count),
      .wr_count  (wr_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input int unsigned i);
      return (((i % 2) != 0) ? 32'hBBBB0000 : 32'hAAAA0000) | 32'(i);
   endfunction

   // SRAM model: asynchronous read, write on the clock edge while we_n is low.
   assign sram_dq_i = mem[sram_addr[7:0]];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= pat(i);
      end else if (sram_we_n === 1'b0) begin
         mem[sram_addr[7:0]] <= sram_dq_o;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic check_reset(input string t);
      chk({t, "_busy"},      64'(busy),       64'd0);
      chk({t, "_ready"},     64'(ready),      64'd0);
      chk({t, "_rdata"},     rdata,           64'd0);
      chk({t, "_sram_addr"}, 64'(sram_addr),  64'd0);
      chk({t, "_dq_o"},      64'(sram_dq_o),  64'd0);
      chk({t, "_dq_oe"},     64'(sram_dq_oe), 64'd0);
      chk({t, "_we_n"},      64'(sram_we_n),  64'd1);
      chk({t, "_rd_count"},  64'(rd_count),   64'd0);
      chk({t, "_wr_count"},  64'(wr_count),   64'd0);
   endtask

   // Scoreboard consumer: every ready pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (ready === 1'b1) begin
         chk("sb_nonempty_on_ready", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.is_rd) chk("rdata_line", rdata, e.data);
            else         chk("wr_mem_word", 64'(mem[8'(e.word)]), e.data);
         end
      end
   end

   initial begin
      rst      = 1'b1;
      req_rd   = 1'b0;
      req_wr   = 1'b0;
      addr     = '0;
      wdata    = '0;
      mem_init = 1'b1;
      for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);

      repeat (2) step();
      mem_init = 1'b0;
      check_reset("rst_hold");
      rst = 1'b0;
      step();
      check_reset("rst_after");

      // Line read at word 4/5
      req_rd = 1'b1;
      addr   = BASE + 32'd16;
      sb.push_back('{1'b1, {ref_mem[5], ref_mem[4]}, 4});
      for (int k = 1; k <= 12; k++) begin
         step();
         if (k == 1) req_rd = 1'b0;
         if (k <= 5)       chk("rd_addr_lo", 64'(sram_addr), 64'd4);
         else if (k <= 10) chk("rd_addr_hi", 64'(sram_addr), 64'd5);
         if (k <= 10) chk("rd_we_n", 64'(sram_we_n), 64'd1);
         chk("rd_ready", 64'(ready), 64'(k == 11));
         if (k == 12) begin
            chk("rd_count1", 64'(rd_count), 64'd1);
            chk("rd_busy_idle", 64'(busy), 64'd0);
         end
      end

      // Single-word write at word 2
      req_wr = 1'b1;
      addr   = BASE + 32'd8;
      wdata  = 32'hDEADBEEF;
      ref_mem[2] = 32'hDEADBEEF;
      sb.push_back('{1'b0, 64'hDEADBEEF, 2});
      for (int k = 1; k <= 7; k++) begin
         step();
         if (k == 1) req_wr = 1'b0;
         if (k <= 5) begin
            chk("wr_we_n",  64'(sram_we_n),  64'd0);
            chk("wr_addr",  64'(sram_addr),  64'd2);
            chk("wr_oe",    64'(sram_dq_oe), 64'd1);
            chk("wr_dq_o",  64'(sram_dq_o),  64'hDEADBEEF);
         end
         if (k == 6) begin
            chk("wr_done_we_n", 64'(sram_we_n),  64'd1);
            chk("wr_done_oe",   64'(sram_dq_oe), 64'd0);
         end
         chk("wr_ready", 64'(ready), 64'(k == 6));
         if (k == 7) chk("wr_count1", 64'(wr_count), 64'd1);
      end

      // Both requests together: write first, then the still-asserted read of the same line
      req_rd = 1'b1;
      req_wr = 1'b1;
      addr   = BASE + 32'd24;
      wdata  = 32'h12345678;
      ref_mem[6] = 32'h12345678;
      sb.push_back('{1'b0, 64'h12345678, 6});
      sb.push_back('{1'b1, {ref_mem[7], ref_mem[6]}, 6});
      for (int k = 1; k <= 19; k++) begin
         step();
         if (k == 1) req_wr = 1'b0;
         if (k == 8) req_rd = 1'b0;
         chk("both_ready", 64'(ready), 64'((k == 6) || (k == 18)));
         if (k == 3) chk("both_we_n_first", 64'(sram_we_n), 64'd0);
         if (k == 7) chk("both_busy_gap", 64'(busy), 64'd0);
         if (k == 8) begin
            chk("both_busy_rd", 64'(busy), 64'd1);
            chk("both_rd_addr_lo", 64'(sram_addr), 64'd6);
            chk("both_rd_we_n", 64'(sram_we_n), 64'd1);
         end
         if (k == 13) chk("both_rd_addr_hi", 64'(sram_addr), 64'd7);
         if (k == 19) begin
            chk("both_rd_count", 64'(rd_count), 64'd2);
            chk("both_wr_count", 64'(wr_count), 64'd2);
         end
      end

      // Inputs disturbed mid-read must not affect the access in flight
      req_rd = 1'b1;
      addr   = BASE + 32'd32;
      sb.push_back('{1'b1, {ref_mem[9], ref_mem[8]}, 8});
      for (int k = 1; k <= 14; k++) begin
         step();
         if (k == 2) begin
            addr   = BASE + 32'd100;
            req_rd = 1'b0;
         end
         if (k <= 5)       chk("mid_addr_lo", 64'(sram_addr), 64'd8);
         else if (k <= 10) chk("mid_addr_hi", 64'(sram_addr), 64'd9);
         chk("mid_ready", 64'(ready), 64'(k == 11));
         if (k == 12) chk("mid_rd_count", 64'(rd_count), 64'd3);
         if (k == 14) chk("mid_busy_idle", 64'(busy), 64'd0);
      end

      // Reset during a write: abort with no ready and counters cleared
      req_wr = 1'b1;
      addr   = BASE + 32'd40;
      wdata  = 32'hCAFEF00D;
      step();
      req_wr = 1'b0;
      chk("rstw_we_n_c1", 64'(sram_we_n), 64'd0);
      step();
      step();
      chk("rstw_we_n_c3", 64'(sram_we_n), 64'd0);
      rst = 1'b1;
      step();
      check_reset("rst_mid_wr");
      rst = 1'b0;
      step();
      check_reset("rst_mid_release");
      for (int k = 0; k < 8; k++) begin
         step();
         chk("rstw_no_ready", 64'(ready), 64'd0);
      end

      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
